riscv_muldiv_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 21 ++
 rtl/twos_negate.sv | 12 +
 rtl/riscv_muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: M-extension funct3 codes and the mul/div FSM state encoding.
package riscv_pkg;

  localparam int MULDIV_XLEN = 32;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement: passes data through, or negates it when neg_i is set.
module twos_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] data_i,
  input  logic         neg_i,
  output logic [N-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + N'(1)) : data_i;

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with sign correction applied to the final value.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  muldiv_state_e     state_q, state_d;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hi_q, lo_q, opnd_q, hi_d, lo_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              is_div, a_signed, b_signed, sign_a, sign_b;
  logic              div_zero, div_ovf, special, launch;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, int_min, div_in, div_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN:0]     add_sum, shifted, trial;

  // Operand decode (only meaningful while IDLE)
  assign is_div   = funct3[2];
  assign a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed = is_div ? ~funct3[0] : ~funct3[1];
  assign sign_a   = a_signed & op_a[XLEN-1];
  assign sign_b   = b_signed & op_b[XLEN-1];
  assign int_min  = {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = is_div && !funct3[0] && (op_a == int_min) && (op_b == '1);
  assign special  = div_zero || div_ovf;
  assign launch   = (state_q == MD_IDLE) && start && !flush;

  twos_negate #(.N(XLEN)) u_mag_a (.data_i(op_a), .neg_i(sign_a), .data_o(mag_a));
  twos_negate #(.N(XLEN)) u_mag_b (.data_i(op_b), .neg_i(sign_b), .data_o(mag_b));

  always_comb begin
    special_res = '1;
    if (div_zero)     special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : op_a;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (launch) state_d = special ? MD_DONE : MD_BUSY;
      MD_BUSY: begin
        if (flush)                            state_d = MD_IDLE;
        else if (cnt_q == CNT_W'(XLEN - 1))   state_d = MD_DONE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM: outputs, registered alongside the state
  always_comb begin
    busy_d = (state_d == MD_BUSY);
    done_d = (state_d == MD_DONE);
  end

  // One iteration: hi holds partial product / remainder, lo holds multiplier / quotient
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    trial   = shifted - {1'b0, opnd_q};
    if (state_q == MD_BUSY) begin
      if (op_q[2]) begin
        if (!trial[XLEN]) begin
          hi_d = trial[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_d = add_sum[XLEN:1];
        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

  // Sign correction sees the post-iteration values so the result lands on DONE entry
  assign div_in = op_q[1] ? hi_d : lo_d;
  twos_negate #(.N(2*XLEN)) u_neg_prod (.data_i({hi_d, lo_d}), .neg_i(neg_q), .data_o(prod_s));
  twos_negate #(.N(XLEN))   u_neg_div  (.data_i(div_in),       .neg_i(neg_q), .data_o(div_s));

  always_comb begin
    if (op_q[2])                  result_d = div_s;
    else if (op_q == MULDIV_MUL)  result_d = prod_s[XLEN-1:0];
    else                          result_d = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
    end else if (launch) begin
      op_q   <= funct3;
      neg_q  <= (is_div && funct3[1]) ? sign_a : (sign_a ^ sign_b);
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= is_div ? mag_a : mag_b;
      opnd_q <= is_div ? mag_b : mag_a;
      if (special) result_q <= special_res;
    end else if (state_q == MD_BUSY) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (state_d == MD_DONE) result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench for riscv_muldiv_unit: arithmetic reference model with a per-cycle compare,
// plus directed vectors carrying hand-computed results and latencies.
module tb_riscv_muldiv_unit;
  import riscv_pkg::*;

  localparam int XL = 32;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [XL-1:0] op_a = '0, op_b = '0;
  logic          busy, done;
  logic [XL-1:0] result;

  int n_chk = 0, n_fail = 0;

  riscv_muldiv_unit #(.XLEN(XL)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit product of sign/zero-extended operands, SV signed division
  function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    logic [63:0] ea, eb, p;
    int sa, sb;
    sa = a; sb = b;
    ea = (f == MULDIV_MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
    eb = (f == MULDIV_MULHSU || f == MULDIV_MULHU) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (f)
      MULDIV_MUL:  return p[31:0];
      MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: return p[63:32];
      MULDIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
      MULDIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MULDIV_REM:  return (b == 0) ? a :
                          (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      default:     return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XL + 1;
  endfunction

  // Cycle model: m_left counts iteration cycles still owed to the op in flight
  int            m_left = 0;
  logic          m_done = 1'b0;
  logic [XL-1:0] m_result = '0, m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_done   <= 1'b1;
            m_result <= m_pend;
          end
        end
      end else if (!m_done && start && !flush) begin
        if (ref_lat(funct3, op_a, op_b) == 1) begin
          m_done   <= 1'b1;
          m_result <= ref_op(funct3, op_a, op_b);
        end else begin
          m_left <= XL;
          m_pend <= ref_op(funct3, op_a, op_b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy",   {31'd0, busy}, {31'd0, m_left > 0});
      chk("cyc_done",   {31'd0, done}, {31'd0, m_done});
      chk("cyc_result", result, m_result);
    end
  end

  task automatic pulse_start(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom_range(7, 0)); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic wait_done(string nm, int n0, logic [31:0] exp, int lat);
    int  n = n0;
    bit  seen = 0;
    while (!seen && n < 45) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat));
    chk({nm, "_res"}, result, exp);
  endtask

  task automatic run_op(string nm, logic [2:0] f, logic [31:0] a, logic [31:0] b,
                        logic [31:0] exp, int lat);
    chk({nm, "_model"}, ref_op(f, a, b), exp);
    @(posedge clk); #1;
    pulse_start(f, a, b);
    wait_done(nm, 0, exp, lat);
  endtask

  typedef struct {
    string nm; logic [2:0] f; logic [31:0] a, b, exp; int lat;
  } vec_t;

  vec_t vecs[$] = '{
    '{"mul",       MULDIV_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
    '{"mulh",      MULDIV_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33},
    '{"mulhu",     MULDIV_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
    '{"mulhsu",    MULDIV_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33},
    '{"mulh_min",  MULDIV_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33},
    '{"mulhu_2",   MULDIV_MULHU,  32'h8000_0000,  32'd2,         32'd1,         33},
    '{"mul_zero",  MULDIV_MUL,    32'd0,          32'd12345,     32'd0,         33},
    '{"div",       MULDIV_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, 33},
    '{"rem",       MULDIV_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, 33},
    '{"div_nb",    MULDIV_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33},
    '{"rem_nb",    MULDIV_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33},
    '{"divu",      MULDIV_DIVU,   32'd100,        32'd7,         32'd14,        33},
    '{"remu",      MULDIV_REMU,   32'd100,        32'd7,         32'd2,         33},
    '{"divu_big",  MULDIV_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33},
    '{"divu_z",    MULDIV_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1},
    '{"div_z",     MULDIV_DIV,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFFF, 1},
    '{"rem_z",     MULDIV_REM,    32'd5,          32'd0,         32'd5,         1},
    '{"remu_z",    MULDIV_REMU,   32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1},
    '{"div_ovf",   MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{"rem_ovf",   MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1}
  };

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    #19 rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].nm, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Start during the DONE cycle must be ignored
    run_op("divu_b2b", MULDIV_DIVU, 32'd100, 32'd7, 32'd14, 33);
    pulse_start(MULDIV_DIVU, 32'd5, 32'd0);
    chk("done_start_busy", {31'd0, busy}, 32'd0);
    chk("done_start_done", {31'd0, done}, 32'd0);

    // Start while busy must not disturb the latched operands
    @(posedge clk); #1;
    pulse_start(MULDIV_DIVU, 32'd1000, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(MULDIV_MUL, 32'd3, 32'd5);
    wait_done("busy_start", 4, 32'd111, 33);

    // Flush in the middle of a divide: no done, result held, relaunch next cycle
    @(posedge clk); #1;
    pulse_start(MULDIV_DIV, 32'hFFFF_FFEC, 32'd6);
    repeat (2) @(posedge clk);
    #1;
    pulse_start(MULDIV_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (6) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("flush_busy",   {31'd0, busy}, 32'd0);
    chk("flush_done",   {31'd0, done}, 32'd0);
    chk("flush_result", result, 32'd111);
    pulse_start(MULDIV_REMU, 32'd100, 32'd7);
    wait_done("after_flush", 0, 32'd2, 33);

    // Asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    pulse_start(MULDIV_MUL, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, busy}, 32'd0);
    chk("arst_done",   {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    #10 rst = 1'b0;

    // Start and flush together in IDLE: nothing launches
    @(posedge clk); #1;
    flush = 1'b1;
    pulse_start(MULDIV_DIVU, 32'd5, 32'd0);
    flush = 1'b0;
    chk("sf_busy", {31'd0, busy}, 32'd0);
    chk("sf_done", {31'd0, done}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sf_idle_done", {31'd0, done}, 32'd0);

    run_op("final_mul", MULDIV_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
